// File: rtl/branch_resolver.sv
// branch_resolver: execute-side checker for fetch branch predictions.
// Queues every prediction fetch issues, compares the oldest one against the
// resolved outcome, and on a miss pulses o_mispredict with the redirect PC
// while flushing all younger predictions.
// Optional macro BRANCH_STATS_EN adds saturating resolve/mispredict counters.
module branch_resolver #(
    parameter int ADDR_WIDTH = 16,
    parameter int DEPTH      = 4
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rstn,
    input  logic                  i_push,
    input  logic [ADDR_WIDTH-1:0] i_push_pc,
    input  logic                  i_push_taken,
    input  logic [ADDR_WIDTH-1:0] i_push_target,
    input  logic                  i_resolve,
    input  logic                  i_resolve_taken,
    input  logic [ADDR_WIDTH-1:0] i_resolve_target,
    output logic                  o_mispredict,
    output logic [ADDR_WIDTH-1:0] o_correct_pc,
    output logic                  o_full,
    output logic                  o_empty,
    output logic                  o_err
`ifdef BRANCH_STATS_EN
    ,
    output logic [15:0]           o_stat_resolved,
    output logic [15:0]           o_stat_mispredicts
`endif
);

    localparam int PTR_W = $clog2(DEPTH);

    typedef enum logic {RUN = 1'b0, REDIRECT = 1'b1} state_t;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] fallthrough;
        logic                  taken;
        logic [ADDR_WIDTH-1:0] target;
    } entry_t;

    state_t                state_q, state_d;
    logic [PTR_W:0]        wr_ptr_q, wr_ptr_d;
    logic [PTR_W:0]        rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0] correct_pc_q, correct_pc_d;
    logic                  err_q, err_d;
    entry_t                mem_q [DEPTH];

    entry_t                head;
    entry_t                new_entry;
    logic                  full, empty;
    logic                  res_acc, mis, pop, do_push;

    // Extra wrap bit distinguishes full from empty when the indices match.
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
    assign head  = mem_q[rd_ptr_q[PTR_W-1:0]];

    assign new_entry.fallthrough = i_push_pc + 1'b1;
    assign new_entry.taken       = i_push_taken;
    assign new_entry.target      = i_push_target;

    // Only the RUN state accepts resolves; the head must exist.
    assign res_acc = i_resolve && !empty && (state_q == RUN);
    assign mis     = res_acc &&
                     ((head.taken != i_resolve_taken) ||
                      (head.taken && i_resolve_taken && (head.target != i_resolve_target)));
    assign pop     = res_acc && !mis;
    // A push younger than a mispredicting branch is wrong-path and dropped.
    assign do_push = i_push && (state_q == RUN) && !mis && (!full || pop);

    // Next-state: controller, pointers, redirect PC and sticky error.
    always_comb begin
        state_d      = RUN;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        correct_pc_d = correct_pc_q;
        err_d        = err_q;

        if (state_q == REDIRECT) begin
            if (i_resolve) err_d = 1'b1;
        end else begin
            if (i_resolve && empty) err_d = 1'b1;
            if (i_push && full && !pop && !mis) err_d = 1'b1;
        end

        if (mis) begin
            state_d      = REDIRECT;
            rd_ptr_d     = wr_ptr_q;
            correct_pc_d = i_resolve_taken ? i_resolve_target : head.fallthrough;
        end else begin
            if (pop)     rd_ptr_d = rd_ptr_q + 1'b1;
            if (do_push) wr_ptr_d = wr_ptr_q + 1'b1;
        end
    end

    // Control registers; reset discards entries and any pending redirect.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            state_q      <= RUN;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            correct_pc_q <= '0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            correct_pc_q <= correct_pc_d;
            err_q        <= err_d;
        end
    end

    // Prediction storage; validity is tracked purely by the pointers.
    always_ff @(posedge i_sys_clk) begin
        if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= new_entry;
    end

    // The REDIRECT state lasts exactly one cycle, so it is the pulse itself.
    assign o_mispredict = (state_q == REDIRECT);
    assign o_correct_pc = correct_pc_q;
    assign o_full       = full;
    assign o_empty      = empty;
    assign o_err        = err_q;

`ifdef BRANCH_STATS_EN
    logic [15:0] stat_res_q, stat_mis_q;

    // Saturating event counters.
    always_ff @(posedge i_sys_clk or negedge i_sys_rstn) begin
        if (!i_sys_rstn) begin
            stat_res_q <= '0;
            stat_mis_q <= '0;
        end else begin
            if (res_acc && stat_res_q != 16'hFFFF) stat_res_q <= stat_res_q + 1'b1;
            if (mis && stat_mis_q != 16'hFFFF)     stat_mis_q <= stat_mis_q + 1'b1;
        end
    end

    assign o_stat_resolved    = stat_res_q;
    assign o_stat_mispredicts = stat_mis_q;
`endif

endmodule

// File: tb/tb_branch_resolver.sv
// Directed self-checking bench for branch_resolver.
module tb_branch_resolver;

    logic        clk = 1'b0;
    logic        rstn;
    logic        push, push_taken, resolve, resolve_taken;
    logic [15:0] push_pc, push_target, resolve_target;
    logic        mispredict, full, empty, err;
    logic [15:0] correct_pc;
`ifdef BRANCH_STATS_EN
    logic [15:0] stat_res, stat_mis;
`endif

    int tests_run    = 0;
    int tests_failed = 0;

    branch_resolver #(.ADDR_WIDTH(16), .DEPTH(4)) dut (
        .i_sys_clk        (clk),
        .i_sys_rstn       (rstn),
        .i_push           (push),
        .i_push_pc        (push_pc),
        .i_push_taken     (push_taken),
        .i_push_target    (push_target),
        .i_resolve        (resolve),
        .i_resolve_taken  (resolve_taken),
        .i_resolve_target (resolve_target),
        .o_mispredict     (mispredict),
        .o_correct_pc     (correct_pc),
        .o_full           (full),
        .o_empty          (empty),
        .o_err            (err)
`ifdef BRANCH_STATS_EN
        ,
        .o_stat_resolved    (stat_res),
        .o_stat_mispredicts (stat_mis)
`endif
    );

    always #5 clk = ~clk;

    // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        push = 1'b0; resolve = 1'b0;
    endtask

    task automatic set_push(input logic [15:0] pc, input logic tk, input logic [15:0] tg);
        push = 1'b1; push_pc = pc; push_taken = tk; push_target = tg;
    endtask

    task automatic set_res(input logic tk, input logic [15:0] tg);
        resolve = 1'b1; resolve_taken = tk; resolve_target = tg;
    endtask

    task automatic do_reset();
        idle();
        rstn = 1'b0;
        step(); step();
        rstn = 1'b1;
        step();
    endtask

    task automatic test_reset();
        do_reset();
        tests_run++;
        if ({mispredict, correct_pc, full, empty, err} !== {1'b0, 16'h0000, 1'b0, 1'b1, 1'b0}) begin
            tests_failed++;
            $display("FAIL reset: mis=%b pc=%h full=%b empty=%b err=%b, want 0 0000 0 1 0",
                     mispredict, correct_pc, full, empty, err);
        end
    endtask

    task automatic test_correct();
        set_push(16'd35, 1'b1, 16'd52); step(); idle();
        tests_run++;
        if (empty !== 1'b0) begin tests_failed++; $display("FAIL correct_push: empty=%b want 0", empty); end
        set_res(1'b1, 16'd52); step(); idle();
        tests_run++;
        if (mispredict !== 1'b0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL correct_resolve: mis=%b empty=%b, want 0 1", mispredict, empty);
        end
    endtask

    task automatic test_mispredict_nt();
        set_push(16'd36, 1'b1, 16'd52); step(); idle();
        step(); step(); step();
        set_res(1'b0, 16'd0); step(); idle();
        tests_run++;
        if (mispredict !== 1'b1 || correct_pc !== 16'd37 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL mispred_nt: mis=%b pc=%h empty=%b, want 1 0025 1", mispredict, correct_pc, empty);
        end
        step();
        tests_run++;
        if (mispredict !== 1'b0 || correct_pc !== 16'd37) begin
            tests_failed++;
            $display("FAIL mispred_pulse: mis=%b pc=%h, want 0 0025", mispredict, correct_pc);
        end
    endtask

    task automatic test_nt_taken_wrap();
        set_push(16'd38, 1'b0, 16'd0); step(); idle();
        set_res(1'b1, 16'd50); step(); idle();
        tests_run++;
        if (mispredict !== 1'b1 || correct_pc !== 16'd50) begin
            tests_failed++;
            $display("FAIL nt_to_taken: mis=%b pc=%h, want 1 0032", mispredict, correct_pc);
        end
        step();
        set_push(16'hFFFF, 1'b1, 16'h1234); step(); idle();
        set_res(1'b0, 16'd0); step(); idle();
        tests_run++;
        if (mispredict !== 1'b1 || correct_pc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL pc_wrap: mis=%b pc=%h, want 1 0000", mispredict, correct_pc);
        end
        step();
    endtask

    task automatic test_target_mismatch();
        set_push(16'd50, 1'b1, 16'h00F0); step(); idle();
        set_res(1'b1, 16'h0032); step(); idle();
        tests_run++;
        if (mispredict !== 1'b1 || correct_pc !== 16'h0032 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL target_mismatch: mis=%b pc=%h empty=%b, want 1 0032 1", mispredict, correct_pc, empty);
        end
        step();
    endtask

    task automatic test_back_to_back();
        set_push(16'd70, 1'b1, 16'd80); step();
        set_push(16'd71, 1'b0, 16'd0); set_res(1'b1, 16'd80); step(); idle();
        tests_run++;
        if (mispredict !== 1'b0 || empty !== 1'b0 || full !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_pushpop: mis=%b empty=%b full=%b, want 0 0 0", mispredict, empty, full);
        end
        set_res(1'b0, 16'd0); step(); idle();
        tests_run++;
        if (mispredict !== 1'b0 || empty !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL b2b_second: mis=%b empty=%b err=%b, want 0 1 0", mispredict, empty, err);
        end
    endtask

    task automatic test_full();
        for (int i = 1; i <= 4; i++) begin
            set_push(16'(i), 1'b1, 16'd10); step();
        end
        idle();
        tests_run++;
        if (full !== 1'b1 || err !== 1'b0) begin
            tests_failed++;
            $display("FAIL full: full=%b err=%b, want 1 0", full, err);
        end
        set_push(16'd5, 1'b1, 16'd10); step(); idle();
        tests_run++;
        if (full !== 1'b1 || err !== 1'b1) begin
            tests_failed++;
            $display("FAIL overflow: full=%b err=%b, want 1 1", full, err);
        end
        // Head is pc=1 predicted taken; resolving not-taken misses while pc=60 is pushed.
        set_push(16'd60, 1'b1, 16'd10); set_res(1'b0, 16'd0); step(); idle();
        tests_run++;
        if (mispredict !== 1'b1 || correct_pc !== 16'd2 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL flush_push: mis=%b pc=%h empty=%b, want 1 0002 1", mispredict, correct_pc, empty);
        end
        step();
        tests_run++;
        if (empty !== 1'b1 || mispredict !== 1'b0) begin
            tests_failed++;
            $display("FAIL flush_after: empty=%b mis=%b, want 1 0", empty, mispredict);
        end
    endtask

    task automatic test_stats();
`ifdef BRANCH_STATS_EN
        tests_run++;
        if (stat_res !== 16'd8 || stat_mis !== 16'd5) begin
            tests_failed++;
            $display("FAIL stats: resolved=%0d mispredicts=%0d, want 8 5", stat_res, stat_mis);
        end
`endif
    endtask

    task automatic test_mid_reset();
        for (int i = 0; i < 3; i++) begin
            set_push(16'(100 + i), 1'b1, 16'd200); step();
        end
        idle();
        set_res(1'b0, 16'd0);
        #2 rstn = 1'b0;
        step(); idle();
        tests_run++;
        if (mispredict !== 1'b0 || empty !== 1'b1 || err !== 1'b0 || correct_pc !== 16'h0000) begin
            tests_failed++;
            $display("FAIL mid_reset: mis=%b empty=%b err=%b pc=%h, want 0 1 0 0000",
                     mispredict, empty, err, correct_pc);
        end
        rstn = 1'b1;
        step();
        tests_run++;
        if (mispredict !== 1'b0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL post_reset: mis=%b empty=%b, want 0 1", mispredict, empty);
        end
`ifdef BRANCH_STATS_EN
        tests_run++;
        if (stat_res !== 16'd0 || stat_mis !== 16'd0) begin
            tests_failed++;
            $display("FAIL stats_reset: resolved=%0d mispredicts=%0d, want 0 0", stat_res, stat_mis);
        end
`endif
    endtask

    task automatic test_resolve_empty();
        set_res(1'b1, 16'd5); step(); idle();
        tests_run++;
        if (err !== 1'b1 || mispredict !== 1'b0 || empty !== 1'b1) begin
            tests_failed++;
            $display("FAIL resolve_empty: err=%b mis=%b empty=%b, want 1 0 1", err, mispredict, empty);
        end
    endtask

    initial begin
        rstn = 1'b0;
        push = 1'b0; push_pc = '0; push_taken = 1'b0; push_target = '0;
        resolve = 1'b0; resolve_taken = 1'b0; resolve_target = '0;
        #1;
        test_reset();
        test_correct();
        test_mispredict_nt();
        test_nt_taken_wrap();
        test_target_mismatch();
        test_back_to_back();
        test_full();
        test_stats();
        test_mid_reset();
        test_resolve_empty();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
